// File: rtl/csa_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Imported by the arbiter top and its 16-bit carry-select adder.
package csa_pkg;

  localparam int HALF_W      = 16;
  localparam int FULL_W      = 32;
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  function automatic logic [NUM_CLIENTS-1:0] id2oh(
    input logic id
  );
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/csa_add_arbiter_csa16.sv
// 16-bit carry-select adder: 4-bit blocks, each computed
// for both carry-in values and selected by the incoming carry.
module V_CSA16
  import csa_pkg::*;
(
  input  logic [HALF_W-1:0] i_a,
  input  logic [HALF_W-1:0] i_b,
  input  logic              i_cin,
  output logic [HALF_W-1:0] o_sum,
  output logic              o_cout
);

  localparam int BLK  = 4;
  localparam int NBLK = HALF_W / BLK;

  logic [BLK:0] w_s0;
  logic [BLK:0] w_s1;
  logic         w_carry;

  always_comb begin
    w_carry = i_cin;
    w_s0    = '0;
    w_s1    = '0;
    o_sum   = '0;
    for (int i = 0; i < NBLK; i++) begin
      w_s0 = {1'b0, i_a[i*BLK +: BLK]}
           + {1'b0, i_b[i*BLK +: BLK]};
      w_s1 = {1'b0, i_a[i*BLK +: BLK]}
           + {1'b0, i_b[i*BLK +: BLK]}
           + (BLK+1)'(1);
      o_sum[i*BLK +: BLK] = w_carry ? w_s1[BLK-1:0]
                                    : w_s0[BLK-1:0];
      w_carry = w_carry ? w_s1[BLK] : w_s0[BLK];
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/csa_add_arbiter.sv
// Round-robin sharing of one 16-bit carry-select adder between
// two clients; 32-bit adds take a low pass then a high pass.
module csa_add_arbiter
  import csa_pkg::*;
#(
  parameter int RR_INIT = 0,
  parameter int WIDE_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [NUM_CLIENTS-1:0] wide,
  input  logic [FULL_W-1:0]      opa0,
  input  logic [FULL_W-1:0]      opb0,
  input  logic                   cin0,
  input  logic [FULL_W-1:0]      opa1,
  input  logic [FULL_W-1:0]      opb1,
  input  logic                   cin1,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic                   busy,
  output logic [NUM_CLIENTS-1:0] done,
  output logic [FULL_W-1:0]      sum,
  output logic                   cout
);

  localparam logic P_PTR0 = (RR_INIT != 0);
  localparam logic P_WIDE = (WIDE_EN != 0);

  state_t r_state;
  logic   r_id;
  logic   r_wide;
  logic   r_carry;
  logic   r_ptr;

  logic              w_pick;
  logic              w_pick_wide;
  logic [FULL_W-1:0] w_a;
  logic [FULL_W-1:0] w_b;
  logic              w_cin;
  logic              w_hi;
  logic [HALF_W-1:0] w_add_a;
  logic [HALF_W-1:0] w_add_b;
  logic [HALF_W-1:0] w_add_sum;
  logic              w_add_cin;
  logic              w_add_cout;

  always_comb begin
    w_pick = r_ptr;
    unique case (1'b1)
      (req == 2'b01): w_pick = 1'b0;
      (req == 2'b10): w_pick = 1'b1;
      default:        w_pick = r_ptr;
    endcase
  end

  assign w_pick_wide = (w_pick ? wide[1] : wide[0]) & P_WIDE;

  // Operands are read live; clients hold them until done.
  assign w_a   = r_id ? opa1 : opa0;
  assign w_b   = r_id ? opb1 : opb0;
  assign w_cin = r_id ? cin1 : cin0;
  assign w_hi  = (r_state == HI);

  assign w_add_a = w_hi ? w_a[FULL_W-1:HALF_W]
                        : w_a[HALF_W-1:0];
  assign w_add_b = w_hi ? w_b[FULL_W-1:HALF_W]
                        : w_b[HALF_W-1:0];
  assign w_add_cin = w_hi ? r_carry : w_cin;

  V_CSA16 u_csa (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_wide  <= 1'b0;
      r_carry <= 1'b0;
      r_ptr   <= P_PTR0;
      gnt     <= '0;
      done    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= '0;
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_id    <= w_pick;
            r_wide  <= w_pick_wide;
            gnt     <= id2oh(w_pick);
            r_state <= LO;
          end
        end
        LO: begin
          sum[HALF_W-1:0] <= w_add_sum;
          r_carry         <= w_add_cout;
          if (r_wide) begin
            r_state <= HI;
          end else begin
            sum[FULL_W-1:HALF_W] <= '0;
            cout                 <= w_add_cout;
            done                 <= id2oh(r_id);
            r_state              <= DONE;
          end
        end
        HI: begin
          sum[FULL_W-1:HALF_W] <= w_add_sum;
          cout                 <= w_add_cout;
          done                 <= id2oh(r_id);
          r_state              <= DONE;
        end
        DONE: begin
          r_ptr   <= ~r_id;
          gnt     <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_add_arbiter.sv
// Scoreboard bench for csa_add_arbiter: per-client expected
// results queued at issue, popped by a monitor on each done.
module tb_csa_add_arbiter;

  typedef struct {
    logic [31:0] s;
    logic        c;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_c  [2];
  logic        wide_c [2];
  logic        cin_c  [2];
  logic [31:0] opa    [2];
  logic [31:0] opb    [2];
  logic [1:0]  req;
  logic [1:0]  wide;

  assign req  = {req_c[1], req_c[0]};
  assign wide = {wide_c[1], wide_c[0]};

  logic [1:0]  gnt;
  logic        busy;
  logic [1:0]  done;
  logic [31:0] sum;
  logic        cout;

  csa_add_arbiter #(.RR_INIT(0), .WIDE_EN(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wide  (wide),
    .opa0  (opa[0]),
    .opb0  (opb[0]),
    .cin0  (cin_c[0]),
    .opa1  (opa[1]),
    .opb1  (opb[1]),
    .cin1  (cin_c[1]),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  logic [1:0]  nw_req;
  logic [1:0]  nw_wide;
  logic [31:0] nw_opa0;
  logic [31:0] nw_opb0;
  logic [31:0] nw_opa1;
  logic [31:0] nw_opb1;
  logic [1:0]  nw_gnt;
  logic        nw_busy;
  logic [1:0]  nw_done;
  logic [31:0] nw_sum;
  logic        nw_cout;

  csa_add_arbiter #(.RR_INIT(1), .WIDE_EN(0)) u_dut_nw (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (nw_req),
    .wide  (nw_wide),
    .opa0  (nw_opa0),
    .opb0  (nw_opb0),
    .cin0  (1'b0),
    .opa1  (nw_opa1),
    .opb1  (nw_opb1),
    .cin1  (1'b0),
    .gnt   (nw_gnt),
    .busy  (nw_busy),
    .done  (nw_done),
    .sum   (nw_sum),
    .cout  (nw_cout)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  res_t        exp_q0[$];
  res_t        exp_q1[$];
  int          exp_who[$];
  logic [31:0] last_s = '0;
  logic        last_c = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: unsigned add of the selected width.
  function automatic res_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic c,
                                 input logic w);
    res_t        r;
    logic [32:0] t;
    logic [16:0] n;
    t = {1'b0, a} + {1'b0, b} + 33'(c);
    n = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c);
    if (w) begin
      r.s = t[31:0];
      r.c = t[32];
    end else begin
      r.s = {16'h0, n[15:0]};
      r.c = n[16];
    end
    return r;
  endfunction

  task automatic push_exp(input int k, input res_t r);
    if (k == 1) exp_q1.push_back(r);
    else exp_q0.push_back(r);
  endtask

  // Monitor: compares every done pulse with the scoreboard.
  initial begin
    int   k;
    int   w;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done != 2'b00) begin
          k = done[1] ? 1 : 0;
          check("done_onehot", done, (k == 1) ? 2 : 1);
          check("gnt_at_done", gnt, done);
          check("busy_at_done", busy, 1);
          if (exp_who.size() > 0) begin
            w = exp_who.pop_front();
            check("rr_order", k, w);
          end
          if ((k == 1 ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got client %0d expected none", k);
          end else begin
            r = (k == 1) ? exp_q1.pop_front()
                         : exp_q0.pop_front();
            check("sum", sum, r.s);
            check("cout", cout, r.c);
          end
          last_s = sum;
          last_c = cout;
        end else if (!busy) begin
          check("hold_result", {cout, sum},
                {last_c, last_s});
        end
      end
    end
  end

  task automatic run_op(input int k,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic ci,
                        input logic w,
                        input logic [31:0] exp_s,
                        input logic exp_c,
                        input int exp_lat,
                        input logic [1:0] exp_g);
    int n;
    bit seen;
    bit gchk;
    @(negedge clk);
    opa[k]    = a;
    opb[k]    = b;
    cin_c[k]  = ci;
    wide_c[k] = w;
    push_exp(k, model(a, b, ci, w));
    req_c[k]  = 1'b1;
    n    = 0;
    seen = 0;
    gchk = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy && !gchk) begin
        check("gnt_during_op", gnt, exp_g);
        gchk = 1;
      end
      if (done[k]) seen = 1;
    end
    req_c[k] = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout: got no done expected done[%0d]", k);
    end else begin
      check("latency", n + 1, exp_lat);
      check("dir_sum", sum, exp_s);
      check("dir_cout", cout, exp_c);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    last_s = '0;
    last_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic client_loop(input int k);
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        w;
    bit          seen;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if (i % 8 == 0) a = 32'hFFFF_FFFF;
      opa[k]    = a;
      opb[k]    = b;
      cin_c[k]  = ci;
      wide_c[k] = w;
      push_exp(k, model(a, b, ci, w));
      req_c[k] = 1'b1;
      seen = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge clk);
        if (done[k]) seen = 1;
      end
      req_c[k] = 1'b0;
      if (!seen) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_timeout: got no done expected done[%0d]", k);
      end
    end
  endtask

  initial begin
    int   t0;
    int   dc[4];
    int   nd;
    int   n;
    bit   seen;
    res_t r;

    for (int k = 0; k < 2; k++) begin
      req_c[k]  = 1'b0;
      wide_c[k] = 1'b0;
      cin_c[k]  = 1'b0;
      opa[k]    = '0;
      opb[k]    = '0;
    end
    nw_req  = '0;
    nw_wide = '0;
    nw_opa0 = '0;
    nw_opb0 = '0;
    nw_opa1 = '0;
    nw_opb1 = '0;

    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    run_op(0, 32'h1234, 32'h0FFF, 1'b1, 1'b0,
           32'h0000_2234, 1'b0, 3, 2'b01);
    run_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 3, 2'b10);
    run_op(0, 32'h0000_FFFF, 32'h1, 1'b0, 1'b1,
           32'h0001_0000, 1'b0, 4, 2'b01);
    run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1,
           32'h0000_0000, 1'b1, 4, 2'b01);

    // Narrow-only instance: RR_INIT=1 serves client 1 first.
    @(negedge clk);
    nw_req = 2'b11;
    seen   = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (nw_done != 2'b00) seen = 1;
    end
    check("nw_first_grant", nw_done, 2'b10);
    nw_req = 2'b00;
    repeat (3) @(negedge clk);
    nw_opa0 = 32'h0001_FFFF;
    nw_opb0 = 32'h1;
    nw_wide = 2'b01;
    nw_req  = 2'b01;
    n    = 0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (nw_done[0]) seen = 1;
    end
    nw_req = 2'b00;
    check("nw_seen", seen, 1);
    check("nw_latency", n + 1, 3);
    check("nw_sum", nw_sum, 32'h0);
    check("nw_cout", nw_cout, 1'b1);

    // Contention from reset: 0,1,0,1 spaced 3 cycles apart.
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      exp_who.push_back(0);
      exp_who.push_back(1);
    end
    opa[0] = 32'h0000_8001; opb[0] = 32'h0000_8000;
    opa[1] = 32'h0000_00F0; opb[1] = 32'h0000_0F0F;
    cin_c[0] = 1'b0; cin_c[1] = 1'b1;
    wide_c[0] = 1'b0; wide_c[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(0, model(opa[0], opb[0], 1'b0, 1'b0));
      push_exp(1, model(opa[1], opb[1], 1'b1, 1'b0));
    end
    req_c[0] = 1'b1;
    req_c[1] = 1'b1;
    nd = 0;
    for (int t = 0; t < 60 && nd < 4; t++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    req_c[0] = 1'b0;
    req_c[1] = 1'b0;
    check("contention_dones", nd, 4);
    if (nd == 4) begin
      for (int i = 1; i < 4; i++)
        check("rr_spacing", dc[i] - dc[i-1], 3);
      check("same_client_gap", dc[2] - dc[0], 6);
    end
    check("rr_queue_empty", exp_who.size(), 0);
    exp_who.delete();

    // Client 0 served, pointer moves to 1; abort a wide op in HI.
    run_op(0, 32'h5, 32'h6, 1'b0, 1'b0,
           32'h0000_000B, 1'b0, 3, 2'b01);
    @(negedge clk);
    opa[0] = 32'h1234_FFFF;
    opb[0] = 32'h0000_0001;
    wide_c[0] = 1'b1;
    req_c[0]  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1);
    rst_n    = 1'b0;
    req_c[0] = 1'b0;
    last_s   = '0;
    last_c   = 1'b0;
    @(negedge clk);
    check("abort_gnt", gnt, 0);
    check("abort_busy_rst", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_who.push_back(0);
    exp_who.push_back(1);
    wide_c[0] = 1'b0;
    push_exp(0, model(opa[0], opb[0], cin_c[0], 1'b0));
    push_exp(1, model(opa[1], opb[1], cin_c[1], 1'b0));
    req_c[0] = 1'b1;
    req_c[1] = 1'b1;
    nd = 0;
    for (int t = 0; t < 30 && nd < 2; t++) begin
      @(negedge clk);
      if (done != 2'b00) nd++;
    end
    req_c[0] = 1'b0;
    req_c[1] = 1'b0;
    check("post_abort_dones", nd, 2);
    exp_who.delete();

    // Randomized traffic from both clients concurrently.
    @(negedge clk);
    fork
      client_loop(0);
      client_loop(1);
    join
    repeat (6) @(negedge clk);
    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
